// File: rtl/case_2_acc_frame_13s.sv
// case_2_acc_frame_13s
//   Frame accumulator for the case_2 multiply-accumulate datapath. Signed
//   products arrive on a valid/ready stream. Each group of FRAME_LEN
//   accepted products is summed with per-step saturation into one signed
//   result. The result is held in an output register behind its own
//   valid/ready handshake.
//
// Ports
//   ap_clk    clock, all logic on the rising edge
//   ap_rst    synchronous active-high reset
//   din       signed product (DIN_WIDTH)
//   din_vld   din valid
//   din_rdy   block accepts din this cycle (registered state and ap_rst only)
//   dout      saturated frame sum (DOUT_WIDTH, signed)
//   dout_vld  dout valid
//   dout_rdy  consumer accepts dout
//   dout_sat  saturation occurred during the frame in dout
//   ap_idle   no partial frame and no pending result (forced high in reset)
module case_2_acc_frame_13s #(
  parameter int DIN_WIDTH  = 13,
  parameter int DOUT_WIDTH = 20,
  parameter int FRAME_LEN  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  din_vld,
  output logic                  din_rdy,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_vld,
  input  logic                  dout_rdy,
  output logic                  dout_sat,
  output logic                  ap_idle
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {S_ACC, S_HOLD} state_t;

  state_t                state, state_nxt;
  logic [DOUT_WIDTH-1:0] acc;
  logic [CNT_W-1:0]      cnt;
  logic                  sat;

  logic [DOUT_WIDTH:0]   sum;
  logic                  ovf;
  logic [DOUT_WIDTH-1:0] clamped;
  logic                  accept;
  logic                  last;

  // One guard bit above the accumulator. Overflow shows up as the guard
  // bit disagreeing with the accumulator MSB. The guard bit then gives
  // the direction of the clamp.
  always_comb begin
    sum     = {acc[DOUT_WIDTH-1], acc}
            + {{(DOUT_WIDTH + 1 - DIN_WIDTH){din[DIN_WIDTH-1]}}, din};
    ovf     = sum[DOUT_WIDTH] ^ sum[DOUT_WIDTH-1];
    clamped = ovf ? {sum[DOUT_WIDTH], {(DOUT_WIDTH-1){~sum[DOUT_WIDTH]}}}
                  : sum[DOUT_WIDTH-1:0];
  end

  always_comb begin
    din_rdy = (state == S_ACC) && !ap_rst;
    accept  = din_vld && din_rdy;
    last    = (cnt == CNT_LAST);
    ap_idle = ap_rst || ((state == S_ACC) && (cnt == '0) && !dout_vld);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_ACC:   if (accept && last)       state_nxt = S_HOLD;
      S_HOLD:  if (dout_vld && dout_rdy) state_nxt = S_ACC;
      default: state_nxt = S_ACC;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= S_ACC;
    else        state <= state_nxt;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc      <= '0;
      cnt      <= '0;
      sat      <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
      dout_sat <= 1'b0;
    end else begin
      if (accept) begin
        if (last) begin
          dout     <= clamped;
          dout_sat <= sat | ovf;
          dout_vld <= 1'b1;
          acc      <= '0;
          cnt      <= '0;
          sat      <= 1'b0;
        end else begin
          acc <= clamped;
          sat <= sat | ovf;
          cnt <= cnt + CNT_W'(1);
        end
      end
      // dout/dout_sat are left untouched after the handshake.
      if ((state == S_HOLD) && dout_vld && dout_rdy) dout_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_case_2_acc_frame_13s.sv
module tb_case_2_acc_frame_13s;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        ap_rst;
  logic [12:0] din      [3];
  logic        din_vld  [3];
  logic        din_rdy  [3];
  logic        dout_vld [3];
  logic        dout_rdy [3];
  logic        dout_sat [3];
  logic        ap_idle  [3];
  logic [19:0] dout0;
  logic [15:0] dout1;
  logic [19:0] dout2;
  int          dout_i   [3];

  assign dout_i[0] = int'($signed(dout0));
  assign dout_i[1] = int'($signed(dout1));
  assign dout_i[2] = int'($signed(dout2));

  // 0: defaults, 1: 16-bit result, 2: single-product frames
  case_2_acc_frame_13s u_dut0 (
    .ap_clk(clk), .ap_rst(ap_rst), .din(din[0]), .din_vld(din_vld[0]),
    .din_rdy(din_rdy[0]), .dout(dout0), .dout_vld(dout_vld[0]),
    .dout_rdy(dout_rdy[0]), .dout_sat(dout_sat[0]), .ap_idle(ap_idle[0]));

  case_2_acc_frame_13s #(.DOUT_WIDTH(16)) u_dut1 (
    .ap_clk(clk), .ap_rst(ap_rst), .din(din[1]), .din_vld(din_vld[1]),
    .din_rdy(din_rdy[1]), .dout(dout1), .dout_vld(dout_vld[1]),
    .dout_rdy(dout_rdy[1]), .dout_sat(dout_sat[1]), .ap_idle(ap_idle[1]));

  case_2_acc_frame_13s #(.FRAME_LEN(1)) u_dut2 (
    .ap_clk(clk), .ap_rst(ap_rst), .din(din[2]), .din_vld(din_vld[2]),
    .din_rdy(din_rdy[2]), .dout(dout2), .dout_vld(dout_vld[2]),
    .dout_rdy(dout_rdy[2]), .dout_sat(dout_sat[2]), .ap_idle(ap_idle[2]));

  int errors = 0;
  int checks = 0;

  // Reference model: plain integer running sum clamped after every product.
  int flen [3] = '{16, 16, 1};
  int maxv [3] = '{524287, 32767, 524287};
  int minv [3] = '{-524288, -32768, -524288};
  int macc [3];
  int mcnt [3];
  bit msat [3];

  typedef struct {
    int k;
    int sum;
    bit sat;
  } exp_t;
  exp_t q[$];

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int rnd13();
    return int'($urandom_range(8191)) - 4096;
  endfunction

  // Monitor: pops one expected result per output handshake and checks
  // hold behaviour while a result is presented.
  bit held  [3];
  int hdout [3];
  bit hsat  [3];
  always begin
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (dout_vld[k] === 1'b1 && ap_rst === 1'b0) begin
        chk("din_rdy_low_in_hold", int'(din_rdy[k]), 0);
        if (held[k]) begin
          chk("hold_dout_stable", dout_i[k], hdout[k]);
          chk("hold_sat_stable", int'(dout_sat[k]), int'(hsat[k]));
        end
        if (dout_rdy[k] === 1'b1) begin
          if (q.size() == 0) begin
            chk("spurious_dout_vld", 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("dout_source", k, e.k);
            chk("dout_value", dout_i[k], e.sum);
            chk("dout_sat", int'(dout_sat[k]), int'(e.sat));
          end
          held[k] = 1'b0;
        end else begin
          held[k]  = 1'b1;
          hdout[k] = dout_i[k];
          hsat[k]  = dout_sat[k];
        end
      end else begin
        held[k] = 1'b0;
      end
    end
  end

  // Entered and left at a falling edge.
  task automatic send(int k, int v, int gap);
    int  n;
    bit  closed;
    n          = 0;
    din[k]     = 13'(v);
    din_vld[k] = 1'b1;
    while (din_rdy[k] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (din_rdy[k] !== 1'b1) begin
      chk("din_rdy_timeout", 0, 1);
      din_vld[k] = 1'b0;
      return;
    end
    @(posedge clk);
    macc[k] = macc[k] + v;
    if (macc[k] > maxv[k]) begin
      macc[k] = maxv[k];
      msat[k] = 1'b1;
    end else if (macc[k] < minv[k]) begin
      macc[k] = minv[k];
      msat[k] = 1'b1;
    end
    mcnt[k]++;
    closed = (mcnt[k] == flen[k]);
    if (closed) begin
      exp_t e;
      e.k = k;
      e.sum = macc[k];
      e.sat = msat[k];
      q.push_back(e);
      macc[k] = 0;
      mcnt[k] = 0;
      msat[k] = 1'b0;
    end
    @(negedge clk);
    if (closed) begin
      chk("dout_vld_latency", int'(dout_vld[k]), 1);
      chk("din_rdy_after_last", int'(din_rdy[k]), 0);
      if (dout_rdy[k] === 1'b1) begin
        din_vld[k] = 1'b0;
        @(negedge clk);
        chk("dout_vld_one_cycle", int'(dout_vld[k]), 0);
        chk("din_rdy_returns", int'(din_rdy[k]), 1);
      end
    end
    if (gap > 0) begin
      din_vld[k] = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    for (int k = 0; k < 3; k++) din_vld[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_din_rdy", int'(din_rdy[k]), 0);
      chk("rst_ap_idle", int'(ap_idle[k]), 1);
      chk("rst_dout_vld", int'(dout_vld[k]), 0);
      chk("rst_dout", dout_i[k], 0);
      chk("rst_dout_sat", int'(dout_sat[k]), 0);
    end
    ap_rst = 1'b0;
    q.delete();
    for (int k = 0; k < 3; k++) begin
      macc[k] = 0;
      mcnt[k] = 0;
      msat[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("post_rst_din_rdy", int'(din_rdy[k]), 1);
      chk("post_rst_ap_idle", int'(ap_idle[k]), 1);
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int mixed[4];
    mixed = '{-4096, 4095, -1, 2};
    ap_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din[k]      = '0;
      din_vld[k]  = 1'b0;
      dout_rdy[k] = 1'b1;
      held[k]     = 1'b0;
    end
    @(negedge clk);
    do_reset();

    // Basic frame: 16 x +3 -> 48
    repeat (16) send(0, 3, 0);

    // Mixed signs with gaps -> 0
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 4; i++) send(0, mixed[i], 1);

    // Random frames with random gaps
    repeat (3 * 16) send(0, rnd13(), int'($urandom_range(2)));

    // Backpressure: result held 10 cycles while din is driven
    dout_rdy[0] = 1'b0;
    repeat (16) send(0, rnd13(), 0);
    repeat (10) begin
      din[0] = 13'(rnd13());
      @(negedge clk);
      chk("bp_dout_vld_held", int'(dout_vld[0]), 1);
    end
    din_vld[0]  = 1'b0;
    dout_rdy[0] = 1'b1;
    @(negedge clk);
    chk("bp_handshake_vld_low", int'(dout_vld[0]), 0);
    chk("bp_din_rdy_back", int'(din_rdy[0]), 1);
    repeat (16) send(0, 2, 0);

    // Reset while a result is pending: it is discarded
    dout_rdy[0] = 1'b0;
    repeat (16) send(0, 5, 0);
    do_reset();
    dout_rdy[0] = 1'b1;

    // Reset mid-frame: partial sum discarded
    repeat (7) send(0, 100, 0);
    do_reset();
    repeat (16) send(0, 1, 0);

    // Saturation with 16-bit result, sticky flag clears per frame
    repeat (16) send(1, 4095, 0);
    repeat (16) send(1, -4096, 0);
    repeat (16) send(1, 1, 0);
    repeat (4 * 16) send(1, rnd13(), int'($urandom_range(1)));

    // Single-product frames
    send(2, -5, 0);
    send(2, 7, 0);
    repeat (20) send(2, rnd13(), 0);

    for (int k = 0; k < 3; k++) din_vld[k] = 1'b0;
    repeat (5) @(negedge clk);
    chk("all_results_seen", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
